// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS32 pipeline control blocks.
// The PC source encoding matches the datapath's existing dirSelPC = {jump, branch}.
package mips_pkg;
  localparam int         REG_ADDR_W = 5;
  localparam logic [4:0] REG_ZERO   = 5'd0;

  localparam logic [1:0] PC_SEL_SEQ = 2'b00;
  localparam logic [1:0] PC_SEL_BR  = 2'b01;
  localparam logic [1:0] PC_SEL_JMP = 2'b10;
endpackage

// File: rtl/hazard_scoreboard.sv
// Three-entry in-flight write tracker (EX, MEM, WB) with two RAW lookup ports.
// kill_ex_i drops the EX entry as it moves to MEM (wrong-path squash).
module hazard_scoreboard #(
  parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W,
  parameter int RF_BYPASS  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_v_i,
  input  logic [REG_ADDR_W-1:0] load_reg_i,
  input  logic                  kill_ex_i,
  input  logic [REG_ADDR_W-1:0] rs_i,
  input  logic [REG_ADDR_W-1:0] rt_i,
  output logic                  hit_rs_o,
  output logic                  hit_rt_o
);
  import mips_pkg::*;

  logic                  ex_v_q, mem_v_q, wb_v_q;
  logic                  ex_v_d, mem_v_d, wb_v_d;
  logic [REG_ADDR_W-1:0] ex_reg_q, mem_reg_q, wb_reg_q;
  logic [REG_ADDR_W-1:0] ex_reg_d, mem_reg_d, wb_reg_d;

  // With a write-through register file the WB entry is already readable by ID.
  function automatic logic lookup(input logic [REG_ADDR_W-1:0] r,
                                  input logic ev, input logic [REG_ADDR_W-1:0] er,
                                  input logic mv, input logic [REG_ADDR_W-1:0] mr,
                                  input logic wv, input logic [REG_ADDR_W-1:0] wr);
    logic wb_hit;
    wb_hit = (RF_BYPASS == 0) && wv && (wr == r);
    return (r != {REG_ADDR_W{1'b0}}) && ((ev && (er == r)) || (mv && (mr == r)) || wb_hit);
  endfunction

  always_comb begin
    ex_v_d    = load_v_i;
    ex_reg_d  = load_reg_i;
    mem_v_d   = ex_v_q & ~kill_ex_i;
    mem_reg_d = ex_reg_q;
    wb_v_d    = mem_v_q;
    wb_reg_d  = mem_reg_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_v_q  <= 1'b0;
      mem_v_q <= 1'b0;
      wb_v_q  <= 1'b0;
    end else begin
      ex_v_q  <= ex_v_d;
      mem_v_q <= mem_v_d;
      wb_v_q  <= wb_v_d;
    end
    ex_reg_q  <= ex_reg_d;
    mem_reg_q <= mem_reg_d;
    wb_reg_q  <= wb_reg_d;
  end

  assign hit_rs_o = lookup(rs_i, ex_v_q, ex_reg_q, mem_v_q, mem_reg_q, wb_v_q, wb_reg_q);
  assign hit_rt_o = lookup(rt_i, ex_v_q, ex_reg_q, mem_v_q, mem_reg_q, wb_v_q, wb_reg_q);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage MIPS32 pipeline without forwarding.
// Priority: taken branch (MEM) > RAW stall (ID) > jump (ID).
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W,
  parameter int RF_BYPASS  = 0,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_wr_en,
  input  logic [REG_ADDR_W-1:0] id_wr_reg,
  input  logic                  id_jump,
  input  logic                  mem_br_taken,
  output logic                  pc_en,
  output logic [1:0]            pc_sel,
  output logic                  ifid_en,
  output logic                  ifid_flush,
  output logic                  ex_bubble,
  output logic [CNT_W-1:0]      stall_count
);
  import mips_pkg::*;

  logic             hit_rs_s, hit_rt_s, stall_s, load_v_s, count_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  hazard_scoreboard #(.REG_ADDR_W(REG_ADDR_W), .RF_BYPASS(RF_BYPASS)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .load_v_i   (load_v_s),
    .load_reg_i (id_wr_reg),
    .kill_ex_i  (mem_br_taken),
    .rs_i       (id_rs),
    .rt_i       (id_rt),
    .hit_rs_o   (hit_rs_s),
    .hit_rt_o   (hit_rt_s)
  );

  assign stall_s  = id_valid & ((id_uses_rs & hit_rs_s) | (id_uses_rt & hit_rt_s));
  assign load_v_s = id_valid & id_wr_en & ~ex_bubble & (id_wr_reg != REG_ADDR_W'(REG_ZERO));
  assign count_s  = ~rst & ~mem_br_taken & stall_s;

  always_comb begin
    pc_en      = 1'b1;
    pc_sel     = PC_SEL_SEQ;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    ex_bubble  = 1'b0;
    if (rst) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      ex_bubble  = 1'b1;
    end else if (mem_br_taken) begin
      pc_sel     = PC_SEL_BR;
      ifid_flush = 1'b1;
      ex_bubble  = 1'b1;
    end else if (stall_s) begin
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      ex_bubble = 1'b1;
    end else if (id_jump) begin
      pc_sel     = PC_SEL_JMP;
      ifid_flush = 1'b1;
    end else begin
      pc_sel = PC_SEL_SEQ;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (count_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_count = cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Table-driven bench: dut0 (no RF bypass, 4-bit counter) and dut1 (bypass, 16-bit) share stimulus.
module tb_pipeline_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst, id_valid, id_uses_rs, id_uses_rt, id_wr_en, id_jump, mem_br_taken;
  logic [4:0]  id_rs, id_rt, id_wr_reg;
  logic        pc_en0, ifid_en0, ifid_flush0, ex_bubble0;
  logic [1:0]  pc_sel0;
  logic [3:0]  cnt0;
  logic        pc_en1, ifid_en1, ifid_flush1, ex_bubble1;
  logic [1:0]  pc_sel1;
  logic [15:0] cnt1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .RF_BYPASS(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wr_en(id_wr_en),
    .id_wr_reg(id_wr_reg), .id_jump(id_jump), .mem_br_taken(mem_br_taken),
    .pc_en(pc_en0), .pc_sel(pc_sel0), .ifid_en(ifid_en0), .ifid_flush(ifid_flush0),
    .ex_bubble(ex_bubble0), .stall_count(cnt0));

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .RF_BYPASS(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wr_en(id_wr_en),
    .id_wr_reg(id_wr_reg), .id_jump(id_jump), .mem_br_taken(mem_br_taken),
    .pc_en(pc_en1), .pc_sel(pc_sel1), .ifid_en(ifid_en1), .ifid_flush(ifid_flush1),
    .ex_bubble(ex_bubble1), .stall_count(cnt1));

  // Output pattern {pc_en, pc_sel, ifid_en, ifid_flush, ex_bubble}
  localparam logic [5:0] NORM = 6'b1_00_1_0_0;
  localparam logic [5:0] STL  = 6'b0_00_0_0_1;
  localparam logic [5:0] RSTO = 6'b0_00_0_1_1;
  localparam logic [5:0] BR   = 6'b1_01_1_1_1;
  localparam logic [5:0] JMP  = 6'b1_10_1_1_0;

  typedef struct {
    logic        rst, v;
    logic [4:0]  rs, rt;
    logic        urs, urt, we;
    logic [4:0]  wr;
    logic        j, br;
    logic [5:0]  o;
    logic [15:0] c0;
    logic        p1;
    logic [15:0] c1;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  function automatic vec_t mk(input logic r, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                              input logic urs, input logic urt, input logic we, input logic [4:0] wr,
                              input logic j, input logic br, input logic [5:0] o,
                              input int c0, input logic p1, input int c1);
    vec_t t;
    t.rst = r; t.v = v; t.rs = rs; t.rt = rt; t.urs = urs; t.urt = urt; t.we = we; t.wr = wr;
    t.j = j; t.br = br; t.o = o; t.c0 = 16'(c0); t.p1 = p1; t.c1 = 16'(c1);
    return t;
  endfunction

  task automatic chk(input string name, input int step, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%0h want=%0h", name, step, act, exp);
    end
  endtask

  // Drive one cycle on the falling edge, queue its expectation, check combinational outputs 1ns later.
  task automatic apply(input vec_t t, input int step);
    vec_t e;
    @(negedge clk);
    rst = t.rst; id_valid = t.v; id_rs = t.rs; id_rt = t.rt; id_uses_rs = t.urs;
    id_uses_rt = t.urt; id_wr_en = t.we; id_wr_reg = t.wr; id_jump = t.j; mem_br_taken = t.br;
    exp_q.push_back(t);
    #1;
    e = exp_q.pop_front();
    chk("pc_en",       step, {15'd0, pc_en0},      {15'd0, e.o[5]});
    chk("pc_sel",      step, {14'd0, pc_sel0},     {14'd0, e.o[4:3]});
    chk("ifid_en",     step, {15'd0, ifid_en0},    {15'd0, e.o[2]});
    chk("ifid_flush",  step, {15'd0, ifid_flush0}, {15'd0, e.o[1]});
    chk("ex_bubble",   step, {15'd0, ex_bubble0},  {15'd0, e.o[0]});
    chk("stall_count", step, {12'd0, cnt0},        e.c0);
    chk("pc_en_byp",   step, {15'd0, pc_en1},      {15'd0, e.p1});
    chk("stall_cnt_byp", step, cnt1,              e.c1);
  endtask

  initial begin
    int c0, c1, step;
    rst = 1'b1; id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_wr_en = 1'b0; id_wr_reg = 5'd0; id_jump = 1'b0; mem_br_taken = 1'b0;
    repeat (2) @(posedge clk);

    //             rst v  rs    rt    urs  urt  we   wr    j    br   out   c0 p1 c1
    tbl.push_back(mk(1, 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, RSTO, 0, 0, 0));
    tbl.push_back(mk(0, 1, 5'd1, 5'd0, 1, 0, 1, 5'd2, 0, 0, NORM, 0, 1, 0)); // lw $2
    tbl.push_back(mk(0, 1, 5'd2, 5'd4, 1, 1, 1, 5'd3, 0, 0, STL,  0, 0, 0)); // add $3,$2,$4
    tbl.push_back(mk(0, 1, 5'd2, 5'd4, 1, 1, 1, 5'd3, 0, 0, STL,  1, 0, 1));
    tbl.push_back(mk(0, 1, 5'd2, 5'd4, 1, 1, 1, 5'd3, 0, 0, STL,  2, 1, 2));
    tbl.push_back(mk(0, 1, 5'd2, 5'd4, 1, 1, 1, 5'd3, 0, 0, NORM, 3, 1, 2));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, NORM, 3, 1, 2));
    tbl.push_back(mk(0, 1, 5'd0, 5'd0, 0, 0, 1, 5'd0, 0, 0, NORM, 3, 1, 2)); // write $0
    tbl.push_back(mk(0, 1, 5'd0, 5'd0, 1, 1, 0, 5'd0, 0, 0, NORM, 3, 1, 2)); // read $0
    tbl.push_back(mk(0, 1, 5'd0, 5'd0, 0, 0, 1, 5'd5, 0, 0, NORM, 3, 1, 2)); // write $5
    tbl.push_back(mk(0, 1, 5'd5, 5'd0, 1, 0, 0, 5'd0, 0, 1, BR,   3, 1, 2)); // branch + stalled reader
    tbl.push_back(mk(0, 1, 5'd5, 5'd0, 1, 0, 0, 5'd0, 0, 0, NORM, 3, 1, 2)); // $5 was squashed
    tbl.push_back(mk(0, 1, 5'd0, 5'd0, 0, 0, 1, 5'd6, 0, 0, NORM, 3, 1, 2)); // write $6
    tbl.push_back(mk(0, 1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, JMP,  3, 1, 2)); // j
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, NORM, 3, 1, 2));
    tbl.push_back(mk(0, 1, 5'd6, 5'd0, 1, 0, 0, 5'd0, 1, 0, STL,  3, 1, 2)); // jr-like: $6 in WB
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, NORM, 4, 1, 2));
    tbl.push_back(mk(0, 1, 5'd0, 5'd0, 0, 0, 1, 5'd7, 0, 0, NORM, 4, 1, 2)); // write $7
    tbl.push_back(mk(0, 1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, NORM, 4, 1, 2)); // independent
    tbl.push_back(mk(0, 1, 5'd0, 5'd7, 0, 1, 0, 5'd0, 0, 0, STL,  4, 0, 2)); // read $7
    tbl.push_back(mk(0, 1, 5'd0, 5'd7, 0, 1, 0, 5'd0, 0, 0, STL,  5, 1, 3));
    tbl.push_back(mk(0, 1, 5'd0, 5'd7, 0, 1, 0, 5'd0, 0, 0, NORM, 6, 1, 3));
    tbl.push_back(mk(0, 1, 5'd0, 5'd0, 0, 0, 1, 5'd8, 0, 0, NORM, 6, 1, 3)); // write $8
    tbl.push_back(mk(0, 1, 5'd8, 5'd0, 1, 0, 0, 5'd0, 0, 0, STL,  6, 0, 3)); // read $8
    tbl.push_back(mk(1, 1, 5'd8, 5'd0, 1, 0, 0, 5'd0, 0, 0, RSTO, 7, 0, 4)); // reset mid-stall
    tbl.push_back(mk(1, 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, RSTO, 0, 0, 0));
    tbl.push_back(mk(0, 1, 5'd8, 5'd0, 1, 0, 0, 5'd0, 0, 0, NORM, 0, 1, 0)); // re-issue, no stall

    step = 0;
    foreach (tbl[i]) begin
      apply(tbl[i], step);
      step++;
    end

    // Seven producer/consumer groups: 21 stalls on dut0 (saturates at 15), 14 on dut1.
    c0 = 0; c1 = 0;
    for (int g = 0; g < 7; g++) begin
      apply(mk(0, 1, 5'd0, 5'd0, 0, 0, 1, 5'd9, 0, 0, NORM, c0, 1'b1, c1), step);
      step++;
      for (int k = 0; k < 4; k++) begin
        apply(mk(0, 1, 5'd9, 5'd0, 1, 0, 0, 5'd0, 0, 0, (k < 3) ? STL : NORM, c0, (k >= 2), c1), step);
        step++;
        if (k < 3) c0 = (c0 == 15) ? 15 : c0 + 1;
        if (k < 2) c1 = c1 + 1;
      end
    end
    apply(mk(0, 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, NORM, 15, 1, 14), step);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
